// File: rtl/fetch_unit_pkg.sv
// Shared pipeline constants for the instruction fetch stage: FSM encoding,
// default reset PC / NOP word and the fixed instruction width in bytes.
package fetch_unit_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;
  localparam logic [1:0] ST_DROP = 2'd3;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_NOP_WORD = 32'h0000_0000;
  localparam logic [31:0] INSTR_BYTES      = 32'd4;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response bus between the fetch unit and imem.
// Handshake: imem_req with a stable imem_addr is held until the cycle
// imem_ready=1; imem_rdata is valid only in that cycle.
interface fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rdata
  );
endinterface

// File: rtl/fetch_unit_next_pc_sel.sv
// Redirect arbitration and sequential PC increment for the fetch stage.
// Execute-stage branches are older than decode-stage jumps, so they win.
module next_pc_sel
  import fetch_unit_pkg::*;
(
  input  logic [31:0] pc_i,
  input  logic        branch_taken_i,
  input  logic [31:0] branch_target_i,
  input  logic        jump_taken_i,
  input  logic [31:0] jump_target_i,
  output logic        redirect_o,
  output logic [31:0] redirect_target_o,
  output logic [31:0] pc_plus4_o
);

  assign redirect_o        = branch_taken_i | jump_taken_i;
  assign redirect_target_o = branch_taken_i ? branch_target_i : jump_target_i;
  // Modulo-2^32 wrap is intentional.
  assign pc_plus4_o        = pc_i + INSTR_BYTES;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch FSM: issues imem requests, registers the fetched word
// into the IF/ID outputs, and handles stalls and branch/jump redirects.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter logic [31:0] NOP_WORD = DEFAULT_NOP_WORD
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               branch_taken,
  input  logic [31:0]        branch_target,
  input  logic               jump_taken,
  input  logic [31:0]        jump_target,
  fetch_unit_if.master       imem,
  output logic               valid_out,
  output logic [31:0]        instruction_out,
  output logic [31:0]        PC_out,
  output logic [1:0]         state_o
);

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pend_pc_q, pend_pc_d;
  logic        valid_q, valid_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_out_q, pc_out_d;

  logic        redirect;
  logic [31:0] redirect_target;
  logic [31:0] pc_plus4;
  logic        capture;

  next_pc_sel u_next_pc_sel (
    .pc_i              (pc_q),
    .branch_taken_i    (branch_taken),
    .branch_target_i   (branch_target),
    .jump_taken_i      (jump_taken),
    .jump_target_i     (jump_target),
    .redirect_o        (redirect),
    .redirect_target_o (redirect_target),
    .pc_plus4_o        (pc_plus4)
  );

  // Only a response to a live (non-dropped) request, with no redirect in the
  // same cycle, reaches the IF/ID register.
  assign capture = (state_q == ST_REQ) && imem.imem_ready && !redirect;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    pend_pc_d = pend_pc_q;
    case (state_q)
      ST_IDLE: begin
        state_d = ST_REQ;
        pc_d    = redirect ? redirect_target : RESET_PC;
      end
      ST_REQ: begin
        if (redirect) begin
          if (imem.imem_ready) begin
            pc_d = redirect_target;
          end else begin
            pend_pc_d = redirect_target;
            state_d   = ST_DROP;
          end
        end else if (imem.imem_ready) begin
          pc_d    = pc_plus4;
          state_d = stall ? ST_HOLD : ST_REQ;
        end
      end
      ST_HOLD: begin
        if (redirect) begin
          pc_d    = redirect_target;
          state_d = ST_REQ;
        end else if (!stall) begin
          state_d = ST_REQ;
        end
      end
      ST_DROP: begin
        // The old request must still complete; its data is thrown away.
        if (redirect) begin
          pend_pc_d = redirect_target;
        end
        if (imem.imem_ready) begin
          pc_d    = redirect ? redirect_target : pend_pc_q;
          state_d = ST_REQ;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    valid_d  = valid_q;
    instr_d  = instr_q;
    pc_out_d = pc_out_q;
    if (redirect) begin
      valid_d = 1'b0;
      instr_d = NOP_WORD;
    end else if (capture) begin
      valid_d  = 1'b1;
      instr_d  = imem.imem_rdata;
      pc_out_d = pc_plus4;
    end else if (!stall) begin
      valid_d = 1'b0;
      instr_d = NOP_WORD;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      pc_q      <= RESET_PC;
      pend_pc_q <= 32'h0;
      valid_q   <= 1'b0;
      instr_q   <= NOP_WORD;
      pc_out_q  <= 32'h0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      pend_pc_q <= pend_pc_d;
      valid_q   <= valid_d;
      instr_q   <= instr_d;
      pc_out_q  <= pc_out_d;
    end
  end

  assign imem.imem_req   = (state_q == ST_REQ) || (state_q == ST_DROP);
  assign imem.imem_addr  = pc_q;
  assign valid_out       = valid_q;
  assign instruction_out = instr_q;
  assign PC_out          = pc_out_q;
  assign state_o         = state_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios with literal expectations, then
// randomized stall/redirect/latency traffic checked against a fetch model.
module tb_fetch_unit;

  localparam logic [31:0] T_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] T_NOP      = 32'h0000_0013;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = 32'h0;
  logic        jump_taken = 1'b0;
  logic [31:0] jump_target = 32'h0;
  logic        tb_ready = 1'b0;
  logic        valid_out;
  logic [31:0] instruction_out;
  logic [31:0] PC_out;
  logic [1:0]  state_o;

  fetch_unit_if mem_if ();

  // Memory returns addr + 0x100 for whatever address the DUT presents.
  assign mem_if.imem_ready = tb_ready;
  assign mem_if.imem_rdata = mem_if.imem_addr + 32'h100;

  fetch_unit #(
    .RESET_PC (T_RESET_PC),
    .NOP_WORD (T_NOP)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .stall           (stall),
    .branch_taken    (branch_taken),
    .branch_target   (branch_target),
    .jump_taken      (jump_taken),
    .jump_target     (jump_target),
    .imem            (mem_if.master),
    .valid_out       (valid_out),
    .instruction_out (instruction_out),
    .PC_out          (PC_out),
    .state_o         (state_o)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural model: an outstanding fetch at m_pc, optionally doomed to be
  // discarded with a pending redirect address; plus the IF/ID register.
  bit          m_req;
  bit          m_discard;
  bit          m_first;
  logic [31:0] m_pc;
  logic [31:0] m_pend;
  bit          m_valid;
  logic [31:0] m_instr;
  logic [31:0] m_pcout;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input bit r, input bit s, input bit bt, input logic [31:0] btg,
                            input bit jt, input logic [31:0] jtg, input bit rdy);
    bit          redir, got, deliver, was_drop;
    logic [31:0] tgt;
    if (r) begin
      m_req = 0; m_discard = 0; m_first = 1;
      m_pc = T_RESET_PC; m_pend = 32'h0;
      m_valid = 0; m_instr = T_NOP; m_pcout = 32'h0;
      return;
    end
    redir   = bt || jt;
    tgt     = bt ? btg : jtg;
    got     = m_req && rdy;
    deliver = got && !m_discard && !redir;
    if (redir) begin
      m_valid = 0; m_instr = T_NOP;
    end else if (deliver) begin
      m_valid = 1; m_instr = m_pc + 32'h100; m_pcout = m_pc + 32'd4;
    end else if (!s) begin
      m_valid = 0; m_instr = T_NOP;
    end
    if (m_req && !got) begin
      if (redir) begin
        m_discard = 1;
        m_pend    = tgt;
      end
    end else begin
      was_drop = m_discard;
      if (redir)         m_pc = tgt;
      else if (was_drop) m_pc = m_pend;
      else if (deliver)  m_pc = m_pc + 32'd4;
      m_req     = m_first || redir || !s || was_drop;
      m_discard = 0;
    end
    m_first = 0;
  endtask

  task automatic check_all();
    chk("valid_out", {31'h0, valid_out}, {31'h0, m_valid});
    chk("instruction_out", instruction_out, m_instr);
    chk("PC_out", PC_out, m_pcout);
    chk("imem_req", {31'h0, mem_if.imem_req}, {31'h0, m_req});
    if (m_req) chk("imem_addr", mem_if.imem_addr, m_pc);
  endtask

  // driver: apply one cycle of inputs, advance the model, compare at negedge
  task automatic step(input bit r, input bit s, input bit bt, input logic [31:0] btg,
                      input bit jt, input logic [31:0] jtg, input bit rdy);
    rst = r; stall = s; branch_taken = bt; branch_target = btg;
    jump_taken = jt; jump_target = jtg; tb_ready = rdy;
    model_step(r, s, bt, btg, jt, jtg, rdy);
    @(negedge clk);
    check_all();
  endtask

  task automatic idle_step(input bit s, input bit rdy);
    step(1'b0, s, 1'b0, 32'h0, 1'b0, 32'h0, rdy);
  endtask

  initial begin
    bit          r, s, bt, jt, rdy;
    logic [31:0] btg, jtg;

    // reset state
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    chk("reset valid_out", {31'h0, valid_out}, 32'h0);
    chk("reset instruction_out", instruction_out, T_NOP);
    chk("reset PC_out", PC_out, 32'h0);
    chk("reset imem_req", {31'h0, mem_if.imem_req}, 32'h0);

    // zero-latency stream
    idle_step(1'b0, 1'b1);
    chk("first imem_addr", mem_if.imem_addr, 32'h0);
    idle_step(1'b0, 1'b1);
    chk("stream instr0", instruction_out, 32'h100);
    chk("stream pc0", PC_out, 32'h4);
    idle_step(1'b0, 1'b1);
    chk("stream instr1", instruction_out, 32'h104);
    chk("stream pc1", PC_out, 32'h8);
    idle_step(1'b0, 1'b1);
    chk("stream instr2", instruction_out, 32'h108);
    chk("stream pc2", PC_out, 32'hC);

    // stall for 3 cycles after the second capture
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    idle_step(1'b0, 1'b1);
    idle_step(1'b0, 1'b1);
    idle_step(1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      chk("stall instr held", instruction_out, 32'h104);
      chk("stall pc held", PC_out, 32'h8);
      chk("stall imem_req", {31'h0, mem_if.imem_req}, 32'h0);
      idle_step(1'b1, 1'b1);
    end
    idle_step(1'b0, 1'b0);
    idle_step(1'b0, 1'b0);
    chk("resume addr", mem_if.imem_addr, 32'h8);

    // jump while the fetch at 8 is still outstanding (latency 2)
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h40, 1'b0);
    chk("drop valid", {31'h0, valid_out}, 32'h0);
    chk("drop addr", mem_if.imem_addr, 32'h8);
    idle_step(1'b0, 1'b0);
    idle_step(1'b0, 1'b1);
    chk("drop discarded", {31'h0, valid_out}, 32'h0);
    chk("after drop addr", mem_if.imem_addr, 32'h40);

    // branch beats jump, and both override a stall
    idle_step(1'b1, 1'b1);
    chk("hold instr", instruction_out, 32'h140);
    step(1'b0, 1'b1, 1'b1, 32'h80, 1'b1, 32'h40, 1'b0);
    chk("prio addr", mem_if.imem_addr, 32'h80);
    chk("prio valid", {31'h0, valid_out}, 32'h0);
    chk("prio instr", instruction_out, T_NOP);

    // pc wrap
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFFC, 1'b1);
    idle_step(1'b0, 1'b1);
    chk("wrap PC_out", PC_out, 32'h0);
    chk("wrap instr", instruction_out, 32'h0000_00FC);
    chk("wrap next addr", mem_if.imem_addr, 32'h0);

    // reset while waiting for ready
    idle_step(1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 32'h200, 1'b0, 32'h0, 1'b0);
    chk("midreset valid", {31'h0, valid_out}, 32'h0);
    chk("midreset instr", instruction_out, T_NOP);
    chk("midreset PC_out", PC_out, 32'h0);
    chk("midreset req", {31'h0, mem_if.imem_req}, 32'h0);
    idle_step(1'b0, 1'b0);
    chk("midreset first addr", mem_if.imem_addr, T_RESET_PC);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      r   = ($urandom_range(0, 199) == 0);
      s   = ($urandom_range(0, 9) < 3);
      bt  = ($urandom_range(0, 19) == 0);
      jt  = ($urandom_range(0, 14) == 0);
      rdy = ($urandom_range(0, 9) < 6);
      btg = $urandom;
      jtg = $urandom;
      if ($urandom_range(0, 3) != 0) btg[1:0] = 2'b00;
      if ($urandom_range(0, 3) != 0) jtg[1:0] = 2'b00;
      if ($urandom_range(0, 49) == 0) jtg = 32'hFFFF_FFF8;
      step(r, s, bt, btg, jt, jtg, rdy);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
